// File: rtl/rat_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rat_pipe_pkg
// Brief    : Shared constants and types for the pipelined RAT core.
// Revision : 1.0  initial release
// ============================================================================
package rat_pipe_pkg;

  // Program counter / ROM address width
  localparam int RAT_PC_W = 10;
  // Instruction width
  localparam int RAT_INSTR_W = 18;
  // Instruction presented when the fetch latch holds nothing valid
  localparam logic [RAT_INSTR_W-1:0] RAT_NOP_WORD = '0;
  // Interrupt vector address
  localparam logic [RAT_PC_W-1:0] RAT_IRQ_VECTOR = 10'h3FF;

  // Hazard state reported by the pipeline controller
  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_STALL    = 2'd1,
    HZ_REDIRECT = 2'd2,
    HZ_FLUSH    = 2'd3
  } hazard_state_e;

  // A control combination the controller must never produce: increment
  // together with redirect or re-issue, or an address re-issue that is not
  // paired with a fetch latch hold (and vice versa).
  function automatic logic illegal_ctrl(input logic inc, input logic load,
                                        input logic mux, input logic stall);
    return (inc & load) | (inc & mux) | (mux ^ stall);
  endfunction

endpackage : rat_pipe_pkg
`default_nettype wire

// File: rtl/fetch_stage_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_sat_counter
// Brief    : Saturating up-counter with synchronous clear.
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins, otherwise increment until all ones and stick there
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : fetch_stage_sat_counter
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch stage: program counter, synchronous ROM
//            addressing, fetch latch toward decode, control sanity flag.
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage
  import rat_pipe_pkg::*;
#(
  parameter int                 PC_W     = RAT_PC_W,
  parameter int                 INSTR_W  = RAT_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_WORD = RAT_NOP_WORD
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pc_inc,
  input  logic               pc_load,
  input  logic               pc_reset,
  input  logic [PC_W-1:0]    load_addr,
  input  logic               imem_addr_mux,
  input  logic               fetch_latch_stall,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               if_valid,
  output logic               ctrl_err,
  output logic [15:0]        fetch_count
);

  logic [PC_W-1:0]    pc_q,       pc_d;
  logic [PC_W-1:0]    addr_q,     addr_d;
  logic               issue_valid_q, issue_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [PC_W-1:0]    if_pc_q,    if_pc_d;
  logic               if_valid_q, if_valid_d;
  logic               ctrl_err_q, ctrl_err_d;
  logic               count_inc;

  // During a stall the ROM is re-fed last cycle's address so its output stays
  // put while the latch is frozen.
  assign imem_addr = imem_addr_mux ? addr_q : pc_q;

  // Program counter next value: flush > redirect > re-issue hold > increment
  always_comb begin
    pc_d = pc_q;
    if (pc_reset) begin
      pc_d = '0;
    end else if (pc_load) begin
      pc_d = load_addr;
    end else if (imem_addr_mux) begin
      pc_d = pc_q;
    end else if (pc_inc) begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  // Remember the address in flight; a redirect or flush this cycle means the
  // address just issued is on the wrong path.
  always_comb begin
    addr_d        = imem_addr;
    issue_valid_d = ~(pc_reset | pc_load);
  end

  // Fetch latch: flush overrides stall; squashed issues enter as NOP bubbles
  always_comb begin
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    if (pc_reset) begin
      if_instr_d = NOP_WORD;
      if_valid_d = 1'b0;
    end else if (!fetch_latch_stall) begin
      if_instr_d = issue_valid_q ? imem_data : NOP_WORD;
      if_pc_d    = addr_q;
      if_valid_d = issue_valid_q;
    end
  end

  // Sticky illegal-control flag, only cleared by the asynchronous reset
  always_comb begin
    ctrl_err_d = ctrl_err_q | illegal_ctrl(pc_inc, pc_load, imem_addr_mux,
                                           fetch_latch_stall);
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= '0;
      addr_q        <= '0;
      issue_valid_q <= 1'b0;
      if_instr_q    <= NOP_WORD;
      if_pc_q       <= '0;
      if_valid_q    <= 1'b0;
      ctrl_err_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      issue_valid_q <= issue_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_valid_q    <= if_valid_d;
      ctrl_err_q    <= ctrl_err_d;
    end
  end

  // A valid instruction enters the latch on a non-stalled, non-flush edge
  assign count_inc = ~pc_reset & ~fetch_latch_stall & issue_valid_q;

  fetch_stage_sat_counter #(
    .WIDTH (16)
  ) u_fetch_count (
    .clk   (clk),
    .rst_n (reset_n),
    .clr   (pc_reset),
    .inc   (count_inc),
    .count (fetch_count)
  );

  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;
  assign if_valid = if_valid_q;
  assign ctrl_err = ctrl_err_q;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage: directed scenarios followed
//            by random control traffic against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

  localparam int              PC_W    = 10;
  localparam int              INSTR_W = 18;
  localparam logic [17:0]     NOP     = 18'h0;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               pc_inc = 1'b0;
  logic               pc_load = 1'b0;
  logic               pc_reset = 1'b0;
  logic [PC_W-1:0]    load_addr = '0;
  logic               imem_addr_mux = 1'b0;
  logic               fetch_latch_stall = 1'b0;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data = '0;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               if_valid;
  logic               ctrl_err;
  logic [15:0]        fetch_count;

  fetch_stage #(
    .PC_W     (PC_W),
    .INSTR_W  (INSTR_W),
    .NOP_WORD (NOP)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .pc_inc            (pc_inc),
    .pc_load           (pc_load),
    .pc_reset          (pc_reset),
    .load_addr         (load_addr),
    .imem_addr_mux     (imem_addr_mux),
    .fetch_latch_stall (fetch_latch_stall),
    .imem_addr         (imem_addr),
    .imem_data         (imem_data),
    .if_instr          (if_instr),
    .if_pc             (if_pc),
    .if_valid          (if_valid),
    .ctrl_err          (ctrl_err),
    .fetch_count       (fetch_count)
  );

  always #5 clk = ~clk;

  // Synchronous instruction ROM: data one cycle after address
  logic [INSTR_W-1:0] mem [1024];
  always @(posedge clk) imem_data <= mem[imem_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pipeline view: every cycle one address is "issued" (tagged good or
  // wrong-path); the ROM answers next cycle; the latch takes that answer.
  int unsigned m_pc;          // architectural program counter
  int unsigned m_last_issue;  // address issued in the previous cycle
  bit          m_last_good;   // was that issue on the correct path
  int unsigned m_l_instr, m_l_pc;
  bit          m_l_valid;
  bit          m_err;
  int unsigned m_count;

  task automatic model_reset();
    m_pc = 0; m_last_issue = 0; m_last_good = 0;
    m_l_instr = NOP; m_l_pc = 0; m_l_valid = 0;
    m_err = 0; m_count = 0;
  endtask

  task automatic check_latch(input string ctx);
    check({ctx, ".if_valid"},    32'(if_valid),    32'(m_l_valid));
    check({ctx, ".if_instr"},    32'(if_instr),    m_l_instr);
    check({ctx, ".if_pc"},       32'(if_pc),       m_l_pc);
    check({ctx, ".ctrl_err"},    32'(ctrl_err),    32'(m_err));
    check({ctx, ".fetch_count"}, 32'(fetch_count), m_count);
  endtask

  // One clock cycle with the given control lines
  task automatic step(input bit inc, input bit load, input bit rst,
                      input bit mux, input bit stall, input int unsigned la);
    int unsigned issue, arriving;
    bit          good;
    @(negedge clk);
    pc_inc = inc; pc_load = load; pc_reset = rst;
    imem_addr_mux = mux; fetch_latch_stall = stall;
    load_addr = PC_W'(la);
    issue = mux ? m_last_issue : m_pc;
    #1 check("imem_addr", 32'(imem_addr), issue);
    @(posedge clk);
    // ROM output at this edge is the word for last cycle's issue
    arriving = mem[m_last_issue];
    good     = m_last_good;
    if (rst) begin
      m_l_valid = 0; m_l_instr = NOP; m_count = 0;
    end else if (!stall) begin
      m_l_valid = good;
      m_l_instr = good ? arriving : NOP;
      m_l_pc    = m_last_issue;
      if (good && m_count < 65535) m_count++;
    end
    if ((inc && load) || (inc && mux) || (mux != stall)) m_err = 1;
    m_last_issue = issue;
    m_last_good  = !(rst || load);
    if (rst)       m_pc = 0;
    else if (load) m_pc = la % 1024;
    else if (mux)  m_pc = m_pc;
    else if (inc)  m_pc = (m_pc + 1) % 1024;
    #1 check_latch("cyc");
  endtask

  // Asynchronous reset: outputs must clear with no clock edge
  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst.imem_addr", 32'(imem_addr), 0);
    check_latch("rst");
    pc_inc = 0; pc_load = 0; pc_reset = 0;
    imem_addr_mux = 0; fetch_latch_stall = 0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic run_random(input int n, input bit allow_illegal);
    for (int i = 0; i < n; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 55)      step(1, 0, 0, 0, 0, 0);
      else if (r < 70) step(0, 0, 0, 1, 1, 0);
      else if (r < 78) step(0, 1, 0, 0, 0, $urandom_range(0, 1023));
      else if (r < 81) step(0, 0, 1, 0, 0, 0);
      else if (r < 86) step(0, 0, 0, 0, 0, 0);
      else if (allow_illegal) begin
        int unsigned b;
        b = $urandom_range(0, 15);
        step(b[0], b[1], 0, b[2], b[3], $urandom_range(0, 1023));
      end else             step(1, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      mem[i] = (i < 64) ? INSTR_W'(32'h100 + i) : INSTR_W'($urandom);
    model_reset();
    #3 apply_reset();

    // Straight-line fetch
    repeat (6) step(1, 0, 0, 0, 0, 0);
    // Stall three cycles, then resume without gap or duplicate
    repeat (3) step(0, 0, 0, 1, 1, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    // Redirect to the top address and watch the PC wrap
    step(0, 1, 0, 0, 0, 10'h3FF);
    repeat (4) step(1, 0, 0, 0, 0, 0);
    // Redirect during a stall wins over the hold
    step(0, 1, 0, 1, 1, 10'h020);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    // Flush mid-stream
    step(0, 0, 1, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0, 0);
    // Increment together with load: load wins and the error sticks
    step(1, 1, 0, 0, 0, 10'h055);
    repeat (4) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // Async reset in the middle of a stall
    repeat (2) step(0, 0, 0, 1, 1, 0);
    #2 apply_reset();

    // Random legal traffic, then traffic including illegal combinations
    run_random(400, 1'b0);
    apply_reset();
    run_random(400, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fetch_stage
`default_nettype wire
